// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
// The LFSR constants are only consumed when LC3_MEM_STALL_EN is defined.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lc3_mem_chan.sv
// One memory port: request capture, IDLE/WAIT/RESP FSM, latency counter,
// registered complete pulse and read data. Storage lives in the parent; this
// block exposes a read/write hook that is active on the edge entering RESP.
// Build option: LC3_MEM_STALL_EN adds 0-3 LFSR-driven extra wait cycles.
module lc3_mem_chan
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LAT    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic [15:0]       i_addr,
    input  logic              i_rd,
    input  logic [15:0]       i_wdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [15:0]       o_mem_wdata,
    input  logic [15:0]       i_mem_rdata,
    output logic              o_complete,
    output logic [15:0]       o_dout
);

    mem_state_t  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_rd;
    logic        r_complete;
    logic [15:0] r_dout;

    logic [1:0]  w_extra;
    logic [15:0] w_total;
    logic        w_accept;
    logic        w_fire;
    logic [15:0] w_fire_addr;
    logic [15:0] w_fire_wdata;
    logic        w_fire_rd;

`ifdef LC3_MEM_STALL_EN
    logic [15:0] r_lfsr;

    // Per-port stall generator, stepped once per accepted request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_lfsr <= LFSR_SEED;
        else if (w_accept)
            r_lfsr <= lfsr_next(r_lfsr);
    end

    assign w_extra = r_lfsr[1:0];
`else
    assign w_extra = 2'd0;
`endif

    // Total cycles for a transaction accepted this cycle
    assign w_total  = 16'(LAT) + {14'd0, w_extra};
    assign w_accept = (r_state == IDLE) && i_req && !i_rst;

    // Storage is touched only on the edge that enters RESP. A single-cycle
    // transaction fires straight from IDLE, so it uses the live inputs rather
    // than the (not yet loaded) capture registers. Reset blocks the hook so a
    // pending store is never written.
    assign w_fire = !i_rst && i_req &&
                    (((r_state == IDLE) && (w_total == 16'd1)) ||
                     ((r_state == WAIT) && (r_cnt == 16'd1)));

    assign w_fire_addr  = (r_state == IDLE) ? i_addr  : r_addr;
    assign w_fire_wdata = (r_state == IDLE) ? i_wdata : r_wdata;
    assign w_fire_rd    = (r_state == IDLE) ? i_rd    : r_rd;

    assign o_mem_addr  = w_fire_addr[ADDR_W-1:0];
    assign o_mem_we    = w_fire && !w_fire_rd;
    assign o_mem_wdata = w_fire_wdata;
    assign o_complete  = r_complete;
    assign o_dout      = r_dout;

    // Request capture; held for the whole transaction, so no reset needed
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_rd    <= i_rd;
        end
    end

    // Port FSM with registered complete pulse and read data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= 16'd0;
            r_complete <= 1'b0;
            r_dout     <= 16'h0000;
        end else begin
            r_complete <= w_fire;
            if (w_fire && w_fire_rd)
                r_dout <= i_mem_rdata;
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        if (w_total == 16'd1) begin
                            r_state <= RESP;
                            r_cnt   <= 16'd0;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= w_total - 16'd1;
                        end
                    end
                end
                WAIT: begin
                    if (!i_req) begin
                        r_state <= IDLE;
                        r_cnt   <= 16'd0;
                    end else if (r_cnt == 16'd1) begin
                        r_state <= RESP;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: shared word storage serving an instruction port and
// a load/store data port, each with its own latency FSM (lc3_mem_chan).
// Build option: LC3_MEM_STALL_EN enables random extra wait cycles per port.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int I_LAT  = 1,
    parameter int D_LAT  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        instrmem_rd,
    input  logic        I_macc,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    input  logic        Data_rd,
    input  logic        D_macc,
    output logic [15:0] Data_dout,
    output logic        complete_data
);

    logic [15:0] r_mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W-1:0] w_i_addr;
    logic              w_i_we;
    logic [15:0]       w_i_wdata;
    logic [15:0]       w_i_rdata;
    logic [ADDR_W-1:0] w_d_addr;
    logic              w_d_we;
    logic [15:0]       w_d_wdata;
    logic [15:0]       w_d_rdata;
    logic              w_unused_ifetch_wr;

    // Combinational reads see the array before this edge's store lands, which
    // gives read-before-write ordering when a fetch and a store collide.
    assign w_i_rdata = r_mem[w_i_addr];
    assign w_d_rdata = r_mem[w_d_addr];

    // The fetch port never writes
    assign w_unused_ifetch_wr = w_i_we ^ (^w_i_wdata);

    lc3_mem_chan #(
        .ADDR_W (ADDR_W),
        .LAT    (I_LAT)
    ) u_ichan (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_req       (I_macc & instrmem_rd),
        .i_addr      (pc),
        .i_rd        (1'b1),
        .i_wdata     (16'h0000),
        .o_mem_addr  (w_i_addr),
        .o_mem_we    (w_i_we),
        .o_mem_wdata (w_i_wdata),
        .i_mem_rdata (w_i_rdata),
        .o_complete  (complete_instr),
        .o_dout      (Instr_dout)
    );

    lc3_mem_chan #(
        .ADDR_W (ADDR_W),
        .LAT    (D_LAT)
    ) u_dchan (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_req       (D_macc),
        .i_addr      (Data_addr),
        .i_rd        (Data_rd),
        .i_wdata     (Data_din),
        .o_mem_addr  (w_d_addr),
        .o_mem_we    (w_d_we),
        .o_mem_wdata (w_d_wdata),
        .i_mem_rdata (w_d_rdata),
        .o_complete  (complete_data),
        .o_dout      (Data_dout)
    );

    // Storage write; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (w_d_we)
            r_mem[w_d_addr] <= w_d_wdata;
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder (ADDR_W=12, I_LAT=2, D_LAT=3).
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// so "complete at the Nth edge after capture" is seen at the Nth negedge.
module tb_lc3_mem_responder;

    localparam int ADDR_W = 12;
    localparam int I_LAT  = 2;
    localparam int D_LAT  = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        instrmem_rd;
    logic        I_macc;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic        Data_rd;
    logic        D_macc;
    logic [15:0] Data_dout;
    logic        complete_data;

    int checks = 0;
    int errors = 0;

    lc3_mem_responder #(
        .ADDR_W (ADDR_W),
        .I_LAT  (I_LAT),
        .D_LAT  (D_LAT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pc),
        .instrmem_rd    (instrmem_rd),
        .I_macc         (I_macc),
        .Instr_dout     (Instr_dout),
        .complete_instr (complete_instr),
        .Data_addr      (Data_addr),
        .Data_din       (Data_din),
        .Data_rd        (Data_rd),
        .D_macc         (D_macc),
        .Data_dout      (Data_dout),
        .complete_data  (complete_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the port idle; returns edges from capture to complete
    task automatic fetch(input logic [15:0] a, output int lat);
        pc = a; I_macc = 1'b1; instrmem_rd = 1'b1; lat = 0;
        @(posedge clock);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (complete_instr) begin
                lat = k;
                break;
            end
        end
        I_macc = 1'b0; instrmem_rd = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic dacc(input logic [15:0] a, input logic [15:0] din, input logic rd,
                        output int lat);
        Data_addr = a; Data_din = din; Data_rd = rd; D_macc = 1'b1; lat = 0;
        @(posedge clock);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (complete_data) begin
                lat = k;
                break;
            end
        end
        D_macc = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        int lat;
        int cnt;
        logic [15:0] mask;
        logic [15:0] m;

        reset = 1'b0; pc = 16'h0; instrmem_rd = 1'b0; I_macc = 1'b0;
        Data_addr = 16'h0; Data_din = 16'h0; Data_rd = 1'b0; D_macc = 1'b0;
        #2 reset = 1'b1;
        @(negedge clock);
        check("rst_complete_instr", {15'd0, complete_instr}, 16'd0);
        check("rst_complete_data",  {15'd0, complete_data},  16'd0);
        check("rst_instr_dout", Instr_dout, 16'h0000);
        check("rst_data_dout",  Data_dout,  16'h0000);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

`ifdef LC3_MEM_STALL_EN
        m = 16'hACE1;
        for (int n = 0; n < 100; n++) begin
            fetch(16'h0010, lat);
            check("stall_fetch_lat", 16'(lat), 16'(I_LAT) + {14'd0, m[1:0]});
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        end
`else
        // store then fetch
        dacc(16'h3000, 16'hBEEF, 1'b0, lat);
        check("store_lat", 16'(lat), 16'd3);
        check("store_pulse_width", {15'd0, complete_data}, 16'd0);
        fetch(16'h3000, lat);
        check("fetch_lat", 16'(lat), 16'd2);
        check("fetch_data", Instr_dout, 16'hBEEF);
        dacc(16'h3000, 16'h0000, 1'b1, lat);
        check("load_lat", 16'(lat), 16'd3);
        check("load_data", Data_dout, 16'hBEEF);

        // address wrap: 0x1005 and 0x0005 share index 0x005
        dacc(16'h1005, 16'h1234, 1'b0, lat);
        dacc(16'h0005, 16'h0000, 1'b1, lat);
        check("wrap_load", Data_dout, 16'h1234);

        // collision: fetch completes on the same edge as a store to 0x040
        dacc(16'h0040, 16'h1111, 1'b0, lat);
        Data_addr = 16'h0040; Data_din = 16'h5555; Data_rd = 1'b0; D_macc = 1'b1;
        @(posedge clock);
        @(negedge clock);
        pc = 16'h0040; I_macc = 1'b1; instrmem_rd = 1'b1;
        @(posedge clock);
        @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        check("coll_complete_data",  {15'd0, complete_data},  16'd1);
        check("coll_complete_instr", {15'd0, complete_instr}, 16'd1);
        check("coll_instr_old", Instr_dout, 16'h1111);
        D_macc = 1'b0; I_macc = 1'b0; instrmem_rd = 1'b0;
        @(posedge clock);
        @(negedge clock);
        fetch(16'h0040, lat);
        check("coll_instr_new", Instr_dout, 16'h5555);

        // abort: request dropped one cycle after capture
        Data_addr = 16'h0040; Data_din = 16'hFFFF; Data_rd = 1'b0; D_macc = 1'b1;
        @(posedge clock);
        @(negedge clock);
        D_macc = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (complete_data) cnt++;
        end
        check("abort_no_complete", 16'(cnt), 16'd0);
        check("abort_dout_held", Data_dout, 16'h1234);
        dacc(16'h0040, 16'h0000, 1'b1, lat);
        check("abort_no_write", Data_dout, 16'h5555);

        // back-to-back fetches with request held: completes at edges 2 and 5
        pc = 16'h3000; I_macc = 1'b1; instrmem_rd = 1'b1; mask = 16'h0;
        @(posedge clock);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (complete_instr) mask[k] = 1'b1;
        end
        I_macc = 1'b0; instrmem_rd = 1'b0;
        check("b2b_pattern", mask, 16'h0012);
        @(posedge clock);
        @(negedge clock);

        // reset while both ports sit in WAIT
        Data_addr = 16'h0005; Data_din = 16'hDEAD; Data_rd = 1'b0; D_macc = 1'b1;
        pc = 16'h0005; I_macc = 1'b1; instrmem_rd = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_complete_instr", {15'd0, complete_instr}, 16'd0);
        check("midrst_complete_data",  {15'd0, complete_data},  16'd0);
        check("midrst_instr_dout", Instr_dout, 16'h0000);
        check("midrst_data_dout",  Data_dout,  16'h0000);
        D_macc = 1'b0; I_macc = 1'b0; instrmem_rd = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (complete_instr || complete_data) cnt++;
        end
        check("midrst_no_complete", 16'(cnt), 16'd0);
        dacc(16'h0005, 16'h0000, 1'b1, lat);
        check("midrst_store_dropped", Data_dout, 16'h1234);
        fetch(16'h3000, lat);
        check("midrst_mem_intact", Instr_dout, 16'hBEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound in case the design never completes a handshake
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
